oddr_serializer: RTL and testbench



---
 rtl/oddr_pkg.sv | 22 ++
 rtl/oddr_out_cell.sv | 31 +++
 rtl/oddr_serializer.sv | 111 +++++++++++
 tb/tb_oddr_serializer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/oddr_pkg.sv
// Shared sizing helpers and the send-order pair selector for the DDR output serializer.
package oddr_pkg;

  localparam int MAX_W = 256;

  function automatic int beats(input int width);
    return width / 2;
  endfunction

  function automatic int cnt_width(input int width);
    return $clog2(width / 2 + 1);
  endfunction

  // Pair {p1, p2} at the front of a word in send order; the word sits in the low `width` bits.
  function automatic logic [1:0] pair_front(input logic [MAX_W-1:0] word, input int width,
                                            input logic lsb_first);
    logic [MAX_W-1:0] top;
    top = word >> (width - 2);
    return lsb_first ? {word[0], word[1]} : {top[1], top[0]};
  endfunction

endpackage

// File: rtl/oddr_out_cell.sv
// DDR output leaf: registers one pair per clock and muxes it onto oq by clock phase.
// Latency: a pair appears one edge after pair_vld; no backpressure, takes a pair every cycle.
module oddr_out_cell #(
  parameter logic IDLE_VAL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] pair,
  input  logic       pair_vld,
  output logic       oq,
  output logic       tq
);

  logic p1, p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1 <= IDLE_VAL;
      p2 <= IDLE_VAL;
      tq <= 1'b1;
    end else begin
      p1 <= pair_vld ? pair[1] : IDLE_VAL;
      p2 <= pair_vld ? pair[0] : IDLE_VAL;
      tq <= ~pair_vld;
    end
  end

  // First bit of the pair during clock high, second during clock low.
  assign oq = clk ? p1 : p2;

endmodule

// File: rtl/oddr_serializer.sv
// DDR serializer: parallel word in over valid/ready, two bits per C cycle out on OQ.
// Latency: first pair one edge after accept; D_READY is low while the hold register is occupied.
module oddr_serializer
  import oddr_pkg::*;
#(
  parameter int   DATA_WIDTH = 8,
  parameter logic LSB_FIRST  = 1'b1,
  parameter logic IDLE_VAL   = 1'b0
) (
  input  logic                  C,
  input  logic                  R_N,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic                  D_VALID,
  output logic                  D_READY,
  output logic                  OQ,
  output logic                  TQ,
  output logic                  BUSY,
  output logic                  WORD_DONE
);

  localparam int N  = beats(DATA_WIDTH);
  localparam int CW = cnt_width(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_REST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(N);

  logic [DATA_WIDTH-1:0] hold, shifter, shifter_nxt;
  logic                  hold_full, hold_full_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [1:0]            pair;
  logic                  pair_vld, last_beat, accept;

  function automatic logic [1:0] front(input logic [DATA_WIDTH-1:0] w);
    return pair_front(MAX_W'(w), DATA_WIDTH, LSB_FIRST);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] w);
    return LSB_FIRST ? (w >> 2) : (w << 2);
  endfunction

  assign D_READY = R_N & ~hold_full;
  assign accept  = D_VALID & D_READY;
  assign BUSY    = hold_full | (cnt != '0) | ~TQ;

  always_comb begin
    shifter_nxt   = shifter;
    cnt_nxt       = cnt;
    hold_full_nxt = hold_full;
    pair          = 2'b00;
    pair_vld      = 1'b0;
    last_beat     = 1'b0;
    if (cnt > CNT_ONE) begin
      pair        = front(shifter);
      pair_vld    = 1'b1;
      shifter_nxt = advance(shifter);
      cnt_nxt     = cnt - CNT_ONE;
    end else if (hold_full) begin
      hold_full_nxt = 1'b0;
      pair_vld      = 1'b1;
      if (cnt == CNT_ONE) begin
        // Last pair leaves now, so the whole hold word is parked and starts on the next edge.
        pair        = front(shifter);
        last_beat   = 1'b1;
        shifter_nxt = hold;
        cnt_nxt     = CNT_FULL;
      end else begin
        pair        = front(hold);
        shifter_nxt = advance(hold);
        cnt_nxt     = CNT_REST;
      end
    end else if (cnt == CNT_ONE) begin
      pair      = front(shifter);
      pair_vld  = 1'b1;
      last_beat = 1'b1;
      cnt_nxt   = '0;
    end
    if (accept) begin
      hold_full_nxt = 1'b1;
    end
  end

  always_ff @(posedge C or negedge R_N) begin
    if (!R_N) begin
      hold      <= '0;
      hold_full <= 1'b0;
      shifter   <= '0;
      cnt       <= '0;
      WORD_DONE <= 1'b0;
    end else begin
      if (accept) begin
        hold <= D;
      end
      hold_full <= hold_full_nxt;
      shifter   <= shifter_nxt;
      cnt       <= cnt_nxt;
      WORD_DONE <= last_beat;
    end
  end

  oddr_out_cell #(
    .IDLE_VAL(IDLE_VAL)
  ) u_out (
    .clk     (C),
    .rst_n   (R_N),
    .pair    (pair),
    .pair_vld(pair_vld),
    .oq      (OQ),
    .tq      (TQ)
  );

endmodule

// File: tb/tb_oddr_serializer.sv
// Three serializers (LSB-first, MSB-first, idle-high) share one stimulus stream; a word/beat-index
// reference model predicts every half-cycle of OQ plus TQ, BUSY, WORD_DONE and D_READY.
module tb_oddr_serializer;

  localparam int W = 8;
  localparam int N = W / 2;

  logic         C, R_N, D_VALID;
  logic [W-1:0] D;
  logic [2:0]   rdy, oq, tq, busy, wd;

  oddr_serializer #(.DATA_WIDTH(W), .LSB_FIRST(1'b1), .IDLE_VAL(1'b0)) dut_lsb (
    .C(C), .R_N(R_N), .D(D), .D_VALID(D_VALID), .D_READY(rdy[0]),
    .OQ(oq[0]), .TQ(tq[0]), .BUSY(busy[0]), .WORD_DONE(wd[0]));

  oddr_serializer #(.DATA_WIDTH(W), .LSB_FIRST(1'b0), .IDLE_VAL(1'b0)) dut_msb (
    .C(C), .R_N(R_N), .D(D), .D_VALID(D_VALID), .D_READY(rdy[1]),
    .OQ(oq[1]), .TQ(tq[1]), .BUSY(busy[1]), .WORD_DONE(wd[1]));

  oddr_serializer #(.DATA_WIDTH(W), .LSB_FIRST(1'b1), .IDLE_VAL(1'b1)) dut_idle1 (
    .C(C), .R_N(R_N), .D(D), .D_VALID(D_VALID), .D_READY(rdy[2]),
    .OQ(oq[2]), .TQ(tq[2]), .BUSY(busy[2]), .WORD_DONE(wd[2]));

  int           n_assert = 0;
  int           n_fail   = 0;
  logic         hold_v, cur_v, out_v, acc;
  logic [W-1:0] hold_w, cur_w, out_w;
  int           cur_k, out_k;
  logic [15:0]  cap0, cap1;

  initial C = 1'b0;
  always #5 C = ~C;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  function automatic logic lane_lsb(input int l);
    return l != 1;
  endfunction

  function automatic logic lane_idle(input int l);
    return l == 2;
  endfunction

  // Bit number i of word w in transmission order.
  function automatic logic send_bit(input logic [W-1:0] w, input int i, input logic lsb);
    logic [W-1:0] t;
    t = lsb ? (w >> i) : (w << i);
    return lsb ? t[0] : t[W-1];
  endfunction

  task automatic chk1(input string tag, input int lane, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s lane%0d: observed %b, expected %b", tag, lane, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hold_v = 1'b0; cur_v = 1'b0; out_v = 1'b0; acc = 1'b0;
    cur_k  = 0;    out_k = 0;
  endtask

  // One posedge: a word waiting in hold becomes current whenever no word is in flight.
  task automatic model_edge();
    logic ready_before;
    acc = 1'b0;
    if (!R_N) begin
      model_reset();
      return;
    end
    ready_before = !hold_v;
    if (!cur_v && hold_v) begin
      cur_w = hold_w; cur_k = 0; cur_v = 1'b1; hold_v = 1'b0;
    end
    out_v = cur_v;
    if (cur_v) begin
      out_w = cur_w;
      out_k = cur_k;
      cur_k++;
      if (cur_k == N) cur_v = 1'b0;
    end
    if (!cur_v && hold_v) begin
      cur_w = hold_w; cur_k = 0; cur_v = 1'b1; hold_v = 1'b0;
    end
    if (D_VALID && ready_before) begin
      hold_w = D; hold_v = 1'b1; acc = 1'b1;
    end
  endtask

  task automatic check_outputs(input logic hi);
    for (int l = 0; l < 3; l++) begin
      logic [1:0] li;
      logic       exp_oq;
      li     = l[1:0];
      exp_oq = out_v ? send_bit(out_w, hi ? 2 * out_k : 2 * out_k + 1, lane_lsb(l))
                     : lane_idle(l);
      chk1(hi ? "oq_high" : "oq_low", l, oq[li], exp_oq);
      chk1("tq", l, tq[li], !out_v);
      chk1("busy", l, busy[li], hold_v || cur_v || out_v);
      chk1("word_done", l, wd[li], out_v && (out_k == N - 1));
      chk1("d_ready", l, rdy[li], R_N && !hold_v);
    end
    if (out_v) begin
      cap0 = {cap0[14:0], oq[0]};
      cap1 = {cap1[14:0], oq[1]};
    end
  endtask

  task automatic cycle();
    @(posedge C);
    model_edge();
    #2 check_outputs(1'b1);
    @(negedge C);
    #2 check_outputs(1'b0);
  endtask

  task automatic send(input logic [W-1:0] w);
    int waited;
    waited  = 0;
    D       = w;
    D_VALID = 1'b1;
    do begin
      cycle();
      waited++;
    end while (!acc && waited < 40);
    if (!acc) begin
      n_fail++;
      $display("FAIL send: word %h not accepted within 40 cycles", w);
    end
    D_VALID = 1'b0;
    D       = W'($urandom);
  endtask

  initial begin
    R_N = 1'b1; D_VALID = 1'b0; D = '0;
    cap0 = '0; cap1 = '0;
    model_reset();
    #1 R_N = 1'b0;
    #2 check_outputs(1'b0);
    repeat (2) cycle();
    R_N = 1'b1;

    // Single word, LSB first: 1,0,1,0,0,1,0,1; MSB-first lane sees the same for 0xA5.
    cap0 = '0; cap1 = '0;
    send(8'hA5);
    repeat (6) cycle();
    chk16("a5_lsb_seq", cap0, 16'h00A5);
    chk16("a5_msb_seq", cap1, 16'h00A5);

    // Back-to-back words with VALID held: 16 contiguous data half-cycles.
    cap0 = '0; cap1 = '0;
    send(8'h0F);
    send(8'hF0);
    repeat (10) cycle();
    chk16("stream_lsb_seq", cap0, 16'hF00F);
    chk16("stream_msb_seq", cap1, 16'h0FF0);

    cap0 = '0; cap1 = '0;
    send(8'h80);
    repeat (6) cycle();
    chk16("w80_msb_seq", cap1, 16'h0080);
    chk16("w80_lsb_seq", cap0, 16'h0001);

    // Reset mid-word after two beats of 0xFF, then a clean word.
    send(8'hFF);
    repeat (2) cycle();
    R_N = 1'b0;
    model_reset();
    #1 check_outputs(1'b0);
    cycle();
    R_N = 1'b1;
    cap0 = '0; cap1 = '0;
    send(8'h3C);
    repeat (6) cycle();
    chk16("post_reset_lsb_seq", cap0, 16'h003C);
    chk16("post_reset_msb_seq", cap1, 16'h003C);

    repeat (20) cycle();

    for (int i = 0; i < 300; i++) begin
      if (!D_VALID) begin
        D       = W'($urandom);
        D_VALID = ($urandom_range(0, 9) < 6);
      end
      cycle();
      if (acc) D_VALID = 1'b0;
    end
    D_VALID = 1'b0;
    repeat (12) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
